serial_exec_ctrl: RTL

- Sequencer for the bit-serial register file and ALU.
- Accepts one decoded instruction per valid/ready handshake and latches it.
- Drives REG_WIDTH cycles of single-bit shift (regfile bit_index and ALU advance together), then a one-cycle parallel write-back from the accumulator.
- Sits between fetch/decode and the regfile/ALU pair; it is the only source of reg_shift_en and reg_store_en.

---
 rtl/serial_exec_ctrl_pkg.sv | 31 +++
 rtl/serial_exec_ctrl_if.sv | 27 ++
 rtl/serial_exec_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/serial_exec_ctrl_pkg.sv
// Shared definitions for the bit-serial execution controller: state encoding,
// ALU op codes, instruction field helpers and default sizing.
package serial_exec_ctrl_pkg;

  localparam int REG_WIDTH_DEF = 8;
  localparam int CNT_W_DEF     = 3;
  localparam int INSTR_W       = 12;
  localparam int OP_W          = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WB    = 2'd2
  } state_e;

  localparam logic [OP_W-1:0] OP_SLLI = 3'b101;
  localparam logic [OP_W-1:0] OP_SRLI = 3'b110;

  localparam int RS1_LSB = 0;
  localparam int RS2_LSB = 4;

  // Register-select fields; rd shares the rs1 slot.
  function automatic logic [2:0] rs1_of(input logic [INSTR_W-1:0] w);
    return w[RS1_LSB +: 3];
  endfunction

  function automatic logic [2:0] rs2_of(input logic [INSTR_W-1:0] w);
    return w[RS2_LSB +: 3];
  endfunction

endpackage

// File: rtl/serial_exec_ctrl_if.sv
// Decode-to-controller instruction handshake (valid/ready plus payload).
interface serial_exec_ctrl_if;
  import serial_exec_ctrl_pkg::*;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_in;
  logic [OP_W-1:0]    alu_op_in;
  logic               wb_req;

  modport master (
    output instr_valid,
    output instr_in,
    output alu_op_in,
    output wb_req,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_in,
    input  alu_op_in,
    input  wb_req,
    output instr_ready
  );

endinterface

// File: rtl/serial_exec_ctrl.sv
// Sequencer for the bit-serial regfile/ALU: accepts one instruction, issues
// REG_WIDTH shift steps, then a single write-back cycle.
module serial_exec_ctrl
  import serial_exec_ctrl_pkg::*;
#(
  parameter int REG_WIDTH = REG_WIDTH_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  serial_exec_ctrl_if.slave  dec,
  input  logic               stall,
  output logic [INSTR_W-1:0] instr,
  output logic [OP_W-1:0]    alu_op,
  output logic               reg_shift_en,
  output logic               reg_store_en,
  output logic [CNT_W-1:0]   bit_cnt,
  output logic               alu_clr,
  output logic               alu_last,
  output logic               busy,
  output logic               done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REG_WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [OP_W-1:0]    alu_op_q, alu_op_d;
  logic               wb_q, wb_d;
  logic               ready_s;
  logic               accept_s;

  assign ready_s         = (state_q == ST_IDLE);
  assign accept_s        = dec.instr_valid & ready_s;
  assign dec.instr_ready = ready_s;
  assign busy            = ~ready_s;
  assign instr           = instr_q;
  assign alu_op          = alu_op_q;
  assign bit_cnt         = bit_cnt_q;

  // State, bit counter and latched instruction registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= CNT_ZERO;
      instr_q   <= {INSTR_W{1'b0}};
      alu_op_q  <= {OP_W{1'b0}};
      wb_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      instr_q   <= instr_d;
      alu_op_q  <= alu_op_d;
      wb_q      <= wb_d;
    end
  end

  // Next-state and counter logic; stall freezes SHIFT and WB only.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    instr_d   = instr_q;
    alu_op_d  = alu_op_q;
    wb_d      = wb_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          instr_d   = dec.instr_in;
          alu_op_d  = dec.alu_op_in;
          wb_d      = dec.wb_req;
          bit_cnt_d = CNT_ZERO;
          state_d   = ST_SHIFT;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (stall) begin
          bit_cnt_d = bit_cnt_q;
        end else if (bit_cnt_q == CNT_LAST) begin
          bit_cnt_d = CNT_ZERO;
          state_d   = ST_WB;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end
      ST_WB: begin
        if (stall) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = CNT_ZERO;
      end
    endcase
  end

  // Strobes decode directly from state, counter and stall so they act this cycle.
  always_comb begin
    reg_shift_en = 1'b0;
    reg_store_en = 1'b0;
    alu_clr      = 1'b0;
    alu_last     = 1'b0;
    done         = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        reg_shift_en = ~stall;
        alu_clr      = (bit_cnt_q == CNT_ZERO) & ~stall;
        alu_last     = (bit_cnt_q == CNT_LAST) & ~stall;
      end
      ST_WB: begin
        reg_store_en = wb_q & ~stall;
        done         = ~stall;
      end
      default: begin
        reg_shift_en = 1'b0;
      end
    endcase
  end

endmodule
